serial_frame_feeder: RTL and testbench

//  Upstream stage of shift_right_register: takes WIDTH-bit parallel words over a valid/ready

---
 rtl/serial_frame_feeder_if.sv | 26 ++
 rtl/serial_frame_feeder.sv | 135 +++++++++++++
 tb/tb_serial_frame_feeder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_feeder_if.sv
// Load handshake and serial output bundle for serial_frame_feeder.
// Master drives words in; slave is the feeder itself.
interface serial_frame_feeder_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             flush;
  logic             ser_out;
  logic             ser_en;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_valid, load_data, flush,
    input  load_ready, ser_out, ser_en,
    input  busy, frame_done
  );

  modport slave (
    input  load_valid, load_data, flush,
    output load_ready, ser_out, ser_en,
    output busy, frame_done
  );
endinterface

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial feeder for a shift-right register.
// One-word holding buffer gives gapless back-to-back frames.
module serial_frame_feeder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  serial_frame_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_sh, w_sh_n;
  logic [WIDTH-1:0] r_buf, w_buf_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_buf_full, w_buf_full_n;
  logic             r_ser_out, w_ser_out_n;
  logic             r_ser_en, w_ser_en_n;
  logic             r_done, w_done_n;
  logic             r_busy, w_busy_n;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sh_adv;

  function automatic logic first_bit(
    input logic [WIDTH-1:0] d
  );
    return LSB_FIRST ? d[0] : d[WIDTH-1];
  endfunction

  assign w_sh_adv = LSB_FIRST ?
    {1'b0, r_sh[WIDTH-1:1]} :
    {r_sh[WIDTH-2:0], 1'b0};

  assign w_accept = bus.load_valid
    && !r_buf_full && !bus.flush;
  assign w_last = (r_state == SHIFT)
    && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_n    = r_state;
    w_sh_n       = r_sh;
    w_buf_n      = r_buf;
    w_cnt_n      = r_cnt;
    w_buf_full_n = r_buf_full;
    w_ser_out_n  = r_ser_out;
    w_ser_en_n   = r_ser_en;
    w_done_n     = 1'b0;
    if (bus.flush) begin
      w_state_n    = IDLE;
      w_cnt_n      = '0;
      w_buf_full_n = 1'b0;
      w_ser_out_n  = 1'b0;
      w_ser_en_n   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_n   = SHIFT;
            w_sh_n      = bus.load_data;
            w_cnt_n     = '0;
            w_ser_out_n = first_bit(bus.load_data);
            w_ser_en_n  = 1'b1;
          end
        end
        SHIFT: begin
          if (w_last) begin
            w_done_n = 1'b1;
            w_cnt_n  = '0;
            // Chain the next word in on the same edge: no idle bit
            if (r_buf_full) begin
              w_sh_n       = r_buf;
              w_ser_out_n  = first_bit(r_buf);
              w_buf_full_n = 1'b0;
            end else if (w_accept) begin
              w_sh_n      = bus.load_data;
              w_ser_out_n = first_bit(bus.load_data);
            end else begin
              w_state_n   = IDLE;
              w_ser_out_n = 1'b0;
              w_ser_en_n  = 1'b0;
            end
          end else begin
            w_cnt_n     = r_cnt + 1'b1;
            w_sh_n      = w_sh_adv;
            w_ser_out_n = first_bit(w_sh_adv);
            if (w_accept) begin
              w_buf_n      = bus.load_data;
              w_buf_full_n = 1'b1;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
    w_busy_n = (w_state_n == SHIFT)
      || w_buf_full_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_buf_full <= 1'b0;
      r_ser_out  <= 1'b0;
      r_ser_en   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_sh       <= w_sh_n;
      r_buf      <= w_buf_n;
      r_cnt      <= w_cnt_n;
      r_buf_full <= w_buf_full_n;
      r_ser_out  <= w_ser_out_n;
      r_ser_en   <= w_ser_en_n;
      r_done     <= w_done_n;
      r_busy     <= w_busy_n;
    end
  end

  assign bus.load_ready = !r_buf_full;
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_en     = r_ser_en;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_serial_frame_feeder.sv
// Directed bench for serial_frame_feeder with a
// behavioural shift-right register downstream.
module tb_serial_frame_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_frame_feeder_if #(.WIDTH(8)) ifl();
  serial_frame_feeder_if #(.WIDTH(8)) ifm();

  serial_frame_feeder #(
    .WIDTH(8), .LSB_FIRST(1'b1)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(ifl)
  );

  serial_frame_feeder #(
    .WIDTH(8), .LSB_FIRST(1'b0)
  ) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(ifm)
  );

  logic [7:0] q;
  logic [7:0] qm;
  always @(posedge clk)
    if (ifl.ser_en) q <= {ifl.ser_out, q[7:1]};
  always @(posedge clk)
    if (ifm.ser_en) qm <= {ifm.ser_out, qm[7:1]};

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_w [3];

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // i = negedges since the first accept edge
  task automatic check_cycle(
    input int i, input int n
  );
    logic [7:0] w;
    if (i < n * 8) begin
      w = exp_w[i / 8];
      chk("ser_en", 32'(ifl.ser_en), 1);
      chk("ser_out", 32'(ifl.ser_out),
          32'(w[i % 8]));
    end else begin
      chk("ser_en_off", 32'(ifl.ser_en), 0);
      chk("ser_out_off", 32'(ifl.ser_out), 0);
    end
    chk("busy", 32'(ifl.busy),
        32'(i < n * 8));
    chk("frame_done", 32'(ifl.frame_done),
        32'(i > 0 && i % 8 == 0));
    if (i > 0 && i % 8 == 0)
      chk("q", 32'(q), 32'(exp_w[i / 8 - 1]));
  endtask

  initial begin
    logic [7:0] m;
    ifl.load_valid = 1'b0;
    ifl.load_data  = '0;
    ifl.flush      = 1'b0;
    ifm.load_valid = 1'b0;
    ifm.load_data  = '0;
    ifm.flush      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ifl.load_ready), 1);
    chk("rst_en", 32'(ifl.ser_en), 0);
    chk("rst_out", 32'(ifl.ser_out), 0);
    chk("rst_busy", 32'(ifl.busy), 0);
    chk("rst_done", 32'(ifl.frame_done), 0);

    // single frame A5
    exp_w[0] = 8'hA5;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'hA5;
    @(negedge clk);
    ifl.load_valid = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      check_cycle(i, 1);
      @(negedge clk);
    end

    // back-to-back A5, 3C
    exp_w[0] = 8'hA5;
    exp_w[1] = 8'h3C;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'hA5;
    @(negedge clk);
    for (int i = 0; i <= 17; i++) begin
      check_cycle(i, 2);
      if (i == 0) ifl.load_data = 8'h3C;
      if (i == 1) begin
        ifl.load_valid = 1'b0;
        chk("b2b_ready", 32'(ifl.load_ready), 0);
      end
      if (i == 8)
        chk("b2b_ready_free",
            32'(ifl.load_ready), 1);
      @(negedge clk);
    end

    // buffer full: 11, 22, 33 offered each cycle
    exp_w[0] = 8'h11;
    exp_w[1] = 8'h22;
    exp_w[2] = 8'h33;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'h11;
    @(negedge clk);
    for (int i = 0; i <= 25; i++) begin
      check_cycle(i, 3);
      if (i == 0) ifl.load_data = 8'h22;
      if (i == 1) begin
        ifl.load_data = 8'h33;
        chk("full_ready", 32'(ifl.load_ready), 0);
      end
      if (i == 7)
        chk("full_hold", 32'(ifl.load_ready), 0);
      if (i == 8)
        chk("full_free", 32'(ifl.load_ready), 1);
      if (i == 9) begin
        ifl.load_valid = 1'b0;
        chk("full_again", 32'(ifl.load_ready), 0);
      end
      @(negedge clk);
    end

    // async reset mid-frame of FF
    exp_w[0] = 8'hFF;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'hFF;
    @(negedge clk);
    ifl.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_cycle(i, 1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(ifl.ser_en), 0);
    chk("arst_out", 32'(ifl.ser_out), 0);
    chk("arst_busy", 32'(ifl.busy), 0);
    chk("arst_done", 32'(ifl.frame_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 32'(ifl.load_ready), 1);
    chk("arst_nodone", 32'(ifl.frame_done), 0);
    exp_w[0] = 8'h5A;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'h5A;
    @(negedge clk);
    ifl.load_valid = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      check_cycle(i, 1);
      @(negedge clk);
    end

    // flush at bit 3 of F0 with 0F buffered
    exp_w[0] = 8'hF0;
    ifl.load_valid = 1'b1;
    ifl.load_data  = 8'hF0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_cycle(i, 1);
      if (i == 0) ifl.load_data = 8'h0F;
      if (i == 1) ifl.load_valid = 1'b0;
      @(negedge clk);
    end
    ifl.flush = 1'b1;
    @(negedge clk);
    ifl.flush = 1'b0;
    chk("fl_en", 32'(ifl.ser_en), 0);
    chk("fl_out", 32'(ifl.ser_out), 0);
    chk("fl_busy", 32'(ifl.busy), 0);
    chk("fl_ready", 32'(ifl.load_ready), 1);
    chk("fl_done", 32'(ifl.frame_done), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("fl_quiet_en", 32'(ifl.ser_en), 0);
      chk("fl_quiet_done",
          32'(ifl.frame_done), 0);
    end

    // MSB-first instance, 80
    m = 8'h80;
    ifm.load_valid = 1'b1;
    ifm.load_data  = m;
    @(negedge clk);
    ifm.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("msb_en", 32'(ifm.ser_en), 1);
      chk("msb_out", 32'(ifm.ser_out),
          32'(m[7 - k]));
      @(negedge clk);
    end
    chk("msb_en_off", 32'(ifm.ser_en), 0);
    chk("msb_done", 32'(ifm.frame_done), 1);
    chk("msb_q", 32'(qm), 32'h01);

    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end
endmodule
